// File: rtl/csc_mat_gen_if.sv
// csc_mat_gen_if
// Bundles the parameter-load handshake and the CSC entry stream of
// csc_mat_gen.
//   parameter side : par_vld/par_rdy, z0, z1, s_r/s_i, a0_r/a0_i, a1_r/a1_i
//   entry stream   : out_vld/out_rdy, col_idx, row_idx, val_r, val_i,
//                    col_ptr, col_last, mat_last, nnz_total
// The master modport is the producer of parameters and consumer of entries
// (the environment); the slave modport is the generator itself.
interface csc_mat_gen_if #(
  parameter int DATA_W       = 32,
  parameter int SUBCAR_NUM   = 16,
  parameter int OFDM_SYM_NUM = 16
);
  localparam int N  = SUBCAR_NUM * OFDM_SYM_NUM;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(3 * N + 1);

  logic              par_vld;
  logic              par_rdy;
  logic [IW-1:0]     z0;
  logic [IW-1:0]     z1;
  logic [DATA_W-1:0] s_r;
  logic [DATA_W-1:0] s_i;
  logic [DATA_W-1:0] a0_r;
  logic [DATA_W-1:0] a0_i;
  logic [DATA_W-1:0] a1_r;
  logic [DATA_W-1:0] a1_i;

  logic              out_vld;
  logic              out_rdy;
  logic [IW-1:0]     col_idx;
  logic [IW-1:0]     row_idx;
  logic [DATA_W-1:0] val_r;
  logic [DATA_W-1:0] val_i;
  logic [PW-1:0]     col_ptr;
  logic              col_last;
  logic              mat_last;
  logic [PW-1:0]     nnz_total;

  modport master (
    output par_vld, z0, z1, s_r, s_i, a0_r, a0_i, a1_r, a1_i, out_rdy,
    input  par_rdy, out_vld, col_idx, row_idx, val_r, val_i,
           col_ptr, col_last, mat_last, nnz_total
  );

  modport slave (
    input  par_vld, z0, z1, s_r, s_i, a0_r, a0_i, a1_r, a1_i, out_rdy,
    output par_rdy, out_vld, col_idx, row_idx, val_r, val_i,
           col_ptr, col_last, mat_last, nnz_total
  );
endinterface

// File: rtl/csc_mat_gen.sv
// csc_mat_gen
// Streams a three-diagonal complex matrix (main diagonal s plus two cyclic
// diagonals a0/a1 offset by z0/z1 rows) in CSC order, one entry per
// out_vld&out_rdy handshake, with running column pointer and total count.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   bus  - csc_mat_gen_if.slave: parameter handshake in, entry stream out
// Build option:
//   CSC_ROW_SORT_EN - when defined, entries of a column leave in ascending
//                     row order; otherwise in diagonal order s, a0, a1.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | par_rdy=1, waiting for a parameter set; stream outputs held at 0
// RUN   | emitting entries column by column until the mat_last handshake
module csc_mat_gen #(
  parameter int DATA_W       = 32,
  parameter int SUBCAR_NUM   = 16,
  parameter int OFDM_SYM_NUM = 16,
  parameter int NNZ_COL      = 3
) (
  input logic          clk,
  input logic          rst,
  csc_mat_gen_if.slave bus
);

  localparam int N  = SUBCAR_NUM * OFDM_SYM_NUM;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(3 * N + 1);

  localparam logic [IW+1:0] N_1X     = (IW + 2)'(N);
  localparam logic [IW+1:0] N_2X     = (IW + 2)'(2 * N);
  localparam logic [IW-1:0] COL_LAST = IW'(N - 1);
  localparam bit            USE_K1   = (NNZ_COL > 1);
  localparam bit            USE_K2   = (NNZ_COL > 2);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [IW-1:0]     z0_q, z1_q;
  logic [DATA_W-1:0] s_r_q, s_i_q, a0_r_q, a0_i_q, a1_r_q, a1_i_q;
  logic [IW-1:0]     col_q;
  logic [1:0]        ent_q;
  logic [PW-1:0]     col_ptr_q;

  logic [IW-1:0]     cand_row [3];
  logic [DATA_W-1:0] cand_r   [3];
  logic [DATA_W-1:0] cand_i   [3];
  logic              cand_v   [3];
  logic [1:0]        cand_rank[3];
  logic              m10, m20, m21;
  logic [1:0]        ent_cnt;
  logic [IW-1:0]     sel_row;
  logic [DATA_W-1:0] sel_r, sel_i;
  logic              last_ent;
  logic              last_col;
  logic              par_hs, out_hs;

  // Offsets may exceed N-1 when N is not a power of two, so the sum can
  // reach up to 3N-2; at most two conditional subtractions give exact mod N.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a,
                                             input logic [IW-1:0] b);
    logic [IW+1:0] sum;
    sum = {2'b00, a} + {2'b00, b};
    if (sum >= N_2X)
      sum = sum - N_2X;
    else if (sum >= N_1X)
      sum = sum - N_1X;
    return IW'(sum);
  endfunction

  // Candidates of the current column. Duplicates fold into the earliest k,
  // which is what keeps k order for the unsorted stream.
  always_comb begin
    cand_row[0] = col_q;
    cand_row[1] = wrap_add(col_q, z0_q);
    cand_row[2] = wrap_add(col_q, z1_q);

    m10 = USE_K1 && (cand_row[1] == cand_row[0]);
    m20 = USE_K2 && (cand_row[2] == cand_row[0]);
    m21 = USE_K2 && (cand_row[2] == cand_row[1]);

    cand_v[0] = 1'b1;
    cand_v[1] = USE_K1 && !m10;
    cand_v[2] = USE_K2 && !m20 && !m21;

    cand_r[0] = s_r_q + (m10 ? a0_r_q : '0) + (m20 ? a1_r_q : '0);
    cand_i[0] = s_i_q + (m10 ? a0_i_q : '0) + (m20 ? a1_i_q : '0);
    cand_r[1] = a0_r_q + (m21 ? a1_r_q : '0);
    cand_i[1] = a0_i_q + (m21 ? a1_i_q : '0);
    cand_r[2] = a1_r_q;
    cand_i[2] = a1_i_q;

    ent_cnt = {1'b0, cand_v[0]} + {1'b0, cand_v[1]} + {1'b0, cand_v[2]};
  end

  // Output slot of each surviving candidate: the number of surviving
  // candidates that must leave before it.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cand_rank[i] = 2'd0;
      for (int j = 0; j < 3; j++) begin
`ifdef CSC_ROW_SORT_EN
        if (j != i && cand_v[j] && (cand_row[j] < cand_row[i]))
          cand_rank[i] = cand_rank[i] + 2'd1;
`else
        if (j < i && cand_v[j])
          cand_rank[i] = cand_rank[i] + 2'd1;
`endif
      end
    end
  end

  always_comb begin
    sel_row = '0;
    sel_r   = '0;
    sel_i   = '0;
    for (int i = 0; i < 3; i++) begin
      if (cand_v[i] && (cand_rank[i] == ent_q)) begin
        sel_row = cand_row[i];
        sel_r   = cand_r[i];
        sel_i   = cand_i[i];
      end
    end
  end

  assign last_ent = (ent_q == (ent_cnt - 2'd1));
  assign last_col = (col_q == COL_LAST);
  assign par_hs   = (state == IDLE) && bus.par_vld;
  assign out_hs   = (state == RUN) && bus.out_rdy;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.par_vld) state_nxt = RUN;
      RUN:  if (bus.out_rdy && last_ent && last_col) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs; everything on the stream side is forced to 0 outside RUN
  always_comb begin
    bus.par_rdy   = (state == IDLE);
    bus.out_vld   = 1'b0;
    bus.col_idx   = '0;
    bus.row_idx   = '0;
    bus.val_r     = '0;
    bus.val_i     = '0;
    bus.col_ptr   = '0;
    bus.col_last  = 1'b0;
    bus.mat_last  = 1'b0;
    bus.nnz_total = '0;
    if (state == RUN) begin
      bus.out_vld   = 1'b1;
      bus.col_idx   = col_q;
      bus.row_idx   = sel_row;
      bus.val_r     = sel_r;
      bus.val_i     = sel_i;
      bus.col_ptr   = col_ptr_q;
      bus.col_last  = last_ent;
      bus.mat_last  = last_ent && last_col;
      bus.nnz_total = col_ptr_q + PW'(ent_cnt);
    end
  end

  // Parameter latch and column/entry walk
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      z0_q      <= '0;
      z1_q      <= '0;
      s_r_q     <= '0;
      s_i_q     <= '0;
      a0_r_q    <= '0;
      a0_i_q    <= '0;
      a1_r_q    <= '0;
      a1_i_q    <= '0;
      col_q     <= '0;
      ent_q     <= '0;
      col_ptr_q <= '0;
    end else if (par_hs) begin
      z0_q      <= bus.z0;
      z1_q      <= bus.z1;
      s_r_q     <= bus.s_r;
      s_i_q     <= bus.s_i;
      a0_r_q    <= bus.a0_r;
      a0_i_q    <= bus.a0_i;
      a1_r_q    <= bus.a1_r;
      a1_i_q    <= bus.a1_i;
      col_q     <= '0;
      ent_q     <= '0;
      col_ptr_q <= '0;
    end else if (out_hs) begin
      if (last_ent) begin
        ent_q     <= '0;
        col_q     <= col_q + IW'(1);
        col_ptr_q <= col_ptr_q + PW'(ent_cnt);
      end else begin
        ent_q <= ent_q + 2'd1;
      end
    end
  end

endmodule

// File: tb/tb_csc_mat_gen.sv
module tb_csc_mat_gen;

  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  csc_mat_gen_if #(.DATA_W(DW), .SUBCAR_NUM(4), .OFDM_SYM_NUM(4)) bus ();

  csc_mat_gen #(
    .DATA_W(DW), .SUBCAR_NUM(4), .OFDM_SYM_NUM(4), .NNZ_COL(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  typedef struct packed {
    logic [3:0]  col;
    logic [3:0]  row;
    logic [31:0] vr;
    logic [31:0] vi;
    logic [5:0]  cp;
    logic        cl;
    logic        ml;
  } ent_t;

  typedef struct {
    int   run_id;
    int   e;
    ent_t exp;
  } vec_t;

  vec_t vecs[$];
  ent_t act[64];
  ent_t expv[64];
  int   act_n, exp_n, act_nnz, exp_nnz, run_cyc, run_gap;
  bit   rdy_high_in_run;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, a, e);
    end
  endtask

  function automatic ent_t mk_ent(input int col, input int row, input logic [31:0] vr,
                                  input logic [31:0] vi, input int cp, input bit cl,
                                  input bit ml);
    ent_t t;
    t.col = 4'(col);
    t.row = 4'(row);
    t.vr  = vr;
    t.vi  = vi;
    t.cp  = 6'(cp);
    t.cl  = cl;
    t.ml  = ml;
    return t;
  endfunction

  function automatic vec_t mk_vec(input int rid, input int e, input ent_t x);
    vec_t v;
    v.run_id = rid;
    v.e      = e;
    v.exp    = x;
    return v;
  endfunction

  function automatic ent_t snap();
    return mk_ent(int'(bus.col_idx), int'(bus.row_idx), bus.val_r, bus.val_i,
                  int'(bus.col_ptr), bus.col_last, bus.mat_last);
  endfunction

  // Reference: gather candidates, merge equal rows by summing, optional row sort
  task automatic build_model(input int z0v, input int z1v,
                             input logic [31:0] sr, input logic [31:0] si,
                             input logic [31:0] a0r, input logic [31:0] a0i,
                             input logic [31:0] a1r, input logic [31:0] a1i);
    int ptr;
    ptr   = 0;
    exp_n = 0;
    for (int c = 0; c < 16; c++) begin
      int          rows[3];
      logic [31:0] kr[3];
      logic [31:0] ki[3];
      int          mr[3];
      logic [31:0] mvr[3];
      logic [31:0] mvi[3];
      int          m;
      rows[0] = c;
      rows[1] = (c + z0v) % 16;
      rows[2] = (c + z1v) % 16;
      kr[0] = sr;  kr[1] = a0r; kr[2] = a1r;
      ki[0] = si;  ki[1] = a0i; ki[2] = a1i;
      m = 0;
      for (int k = 0; k < 3; k++) begin
        int found;
        found = -1;
        for (int j = 0; j < m; j++)
          if (mr[j] == rows[k]) found = j;
        if (found >= 0) begin
          mvr[found] = mvr[found] + kr[k];
          mvi[found] = mvi[found] + ki[k];
        end else begin
          mr[m]  = rows[k];
          mvr[m] = kr[k];
          mvi[m] = ki[k];
          m++;
        end
      end
`ifdef CSC_ROW_SORT_EN
      for (int p = 0; p < m - 1; p++)
        for (int q = 0; q < m - 1 - p; q++)
          if (mr[q] > mr[q+1]) begin
            int          tr;
            logic [31:0] tv;
            tr = mr[q];  mr[q]  = mr[q+1];  mr[q+1]  = tr;
            tv = mvr[q]; mvr[q] = mvr[q+1]; mvr[q+1] = tv;
            tv = mvi[q]; mvi[q] = mvi[q+1]; mvi[q+1] = tv;
          end
`endif
      for (int j = 0; j < m; j++) begin
        expv[exp_n] = mk_ent(c, mr[j], mvr[j], mvi[j], ptr, j == m - 1,
                             (c == 15) && (j == m - 1));
        exp_n++;
      end
      ptr += m;
    end
    exp_nnz = ptr;
  endtask

  task automatic check_reset(input string name);
    chk({name, "_par_rdy"}, 128'(bus.par_rdy), 128'(1'b1));
    chk({name, "_out_vld"}, 128'(bus.out_vld), 128'(1'b0));
    chk({name, "_outs"},
        128'({bus.col_idx, bus.row_idx, bus.val_r, bus.val_i, bus.col_ptr,
              bus.nnz_total, bus.col_last, bus.mat_last}), 128'(0));
  endtask

  // Called at a negedge with the DUT idle. Returns at the negedge after the
  // mat_last handshake, or right after the mid-run reset pulse.
  task automatic do_run(input int z0v, input int z1v,
                        input logic [31:0] sr, input logic [31:0] si,
                        input logic [31:0] a0r, input logic [31:0] a0i,
                        input logic [31:0] a1r, input logic [31:0] a1i,
                        input bit rnd_rdy, input bit hold_vld, input int abort_at);
    ent_t cur, prev;
    bit   prev_stall, done;
    act_n = 0; act_nnz = -1; run_cyc = 0; run_gap = 0;
    rdy_high_in_run = 1'b0;
    prev_stall = 1'b0; done = 1'b0;
    prev = '0;
    for (int i = 0; i < 64; i++) act[i] = '0;
    bus.z0 = 4'(z0v);  bus.z1 = 4'(z1v);
    bus.s_r = sr;      bus.s_i = si;
    bus.a0_r = a0r;    bus.a0_i = a0i;
    bus.a1_r = a1r;    bus.a1_i = a1i;
    bus.par_vld = 1'b1;
    bus.out_rdy = 1'b1;
    @(negedge clk);
    chk("first_vld", 128'(bus.out_vld), 128'(1'b1));
    if (hold_vld) begin
      bus.z0 = 4'(z0v + 5);
      bus.z1 = 4'(z1v + 7);
      bus.s_r = ~sr;
      bus.a1_i = ~a1i;
    end else begin
      bus.par_vld = 1'b0;
    end
    while (!done && run_cyc < 400) begin
      cur = snap();
      if (abort_at >= 0 && act_n == abort_at) begin
        chk("abort_col", 128'(bus.col_idx), 128'(4'd5));
        rst = 1'b1;
        #1;
        check_reset("rst_mid_run");
        @(negedge clk);
        rst = 1'b0;
        bus.par_vld = 1'b0;
        return;
      end
      if (bus.par_rdy) rdy_high_in_run = 1'b1;
      if (prev_stall)
        chk("stall_hold", 128'({bus.out_vld, cur}), 128'({1'b1, prev}));
      bus.out_rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bus.out_vld && bus.out_rdy) begin
        act[act_n] = cur;
        act_n++;
        if (bus.mat_last) begin
          act_nnz = int'(bus.nnz_total);
          done = 1'b1;
        end
      end else if (!bus.out_vld) begin
        run_gap++;
      end
      prev_stall = bus.out_vld && !bus.out_rdy;
      prev = cur;
      run_cyc++;
      @(negedge clk);
    end
    chk("run_done", 128'(done), 128'(1'b1));
    chk("par_rdy_low_in_run", 128'(rdy_high_in_run), 128'(1'b0));
    chk("par_rdy_after_last", 128'(bus.par_rdy), 128'(1'b1));
    chk("out_vld_after_last", 128'(bus.out_vld), 128'(1'b0));
    bus.par_vld = 1'b0;
  endtask

  task automatic compare_model(input string name);
    chk({name, "_count"}, 128'(act_n), 128'(exp_n));
    for (int i = 0; i < exp_n; i++)
      if (i < act_n)
        chk($sformatf("%s_entry%0d", name, i), 128'(act[i]), 128'(expv[i]));
    chk({name, "_nnz_model"}, 128'(act_nnz), 128'(exp_nnz));
  endtask

  task automatic check_table(input int rid);
    foreach (vecs[i])
      if (vecs[i].run_id == rid)
        chk($sformatf("vec_r%0d_e%0d", rid, vecs[i].e), 128'(act[vecs[i].e]),
            128'(vecs[i].exp));
  endtask

  initial begin
    bus.par_vld = 1'b0; bus.out_rdy = 1'b0;
    bus.z0 = '0; bus.z1 = '0;
    bus.s_r = '0; bus.s_i = '0; bus.a0_r = '0; bus.a0_i = '0;
    bus.a1_r = '0; bus.a1_i = '0;

    // run 0: z0=1 z1=2, s=(1,2) a0=(3,4) a1=(5,6)
    vecs.push_back(mk_vec(0, 0,  mk_ent(0, 0, 1, 2, 0, 0, 0)));
    vecs.push_back(mk_vec(0, 1,  mk_ent(0, 1, 3, 4, 0, 0, 0)));
    vecs.push_back(mk_vec(0, 2,  mk_ent(0, 2, 5, 6, 0, 1, 0)));
    vecs.push_back(mk_vec(0, 3,  mk_ent(1, 1, 1, 2, 3, 0, 0)));
`ifdef CSC_ROW_SORT_EN
    vecs.push_back(mk_vec(0, 44, mk_ent(14, 15, 3, 4, 42, 1, 0)));
    vecs.push_back(mk_vec(0, 45, mk_ent(15, 0, 3, 4, 45, 0, 0)));
    vecs.push_back(mk_vec(0, 46, mk_ent(15, 1, 5, 6, 45, 0, 0)));
    vecs.push_back(mk_vec(0, 47, mk_ent(15, 15, 1, 2, 45, 1, 1)));
`else
    vecs.push_back(mk_vec(0, 44, mk_ent(14, 0, 5, 6, 42, 1, 0)));
    vecs.push_back(mk_vec(0, 45, mk_ent(15, 15, 1, 2, 45, 0, 0)));
    vecs.push_back(mk_vec(0, 46, mk_ent(15, 0, 3, 4, 45, 0, 0)));
    vecs.push_back(mk_vec(0, 47, mk_ent(15, 1, 5, 6, 45, 1, 1)));
`endif
    // run 1: z0=0 z1=3, s=(5,-2) a0=(7,1) a1=(9,9); s+a0 = (12,-1)
    vecs.push_back(mk_vec(1, 0,  mk_ent(0, 0, 12, 32'hFFFF_FFFF, 0, 0, 0)));
    vecs.push_back(mk_vec(1, 1,  mk_ent(0, 3, 9, 9, 0, 1, 0)));
`ifdef CSC_ROW_SORT_EN
    vecs.push_back(mk_vec(1, 27, mk_ent(13, 13, 12, 32'hFFFF_FFFF, 26, 1, 0)));
    vecs.push_back(mk_vec(1, 30, mk_ent(15, 2, 9, 9, 30, 0, 0)));
    vecs.push_back(mk_vec(1, 31, mk_ent(15, 15, 12, 32'hFFFF_FFFF, 30, 1, 1)));
`else
    vecs.push_back(mk_vec(1, 27, mk_ent(13, 0, 9, 9, 26, 1, 0)));
    vecs.push_back(mk_vec(1, 30, mk_ent(15, 15, 12, 32'hFFFF_FFFF, 30, 0, 0)));
    vecs.push_back(mk_vec(1, 31, mk_ent(15, 2, 9, 9, 30, 1, 1)));
`endif
    // run 2: z0=z1=0, all three fold; real part wraps past the max positive
    vecs.push_back(mk_vec(2, 0,  mk_ent(0, 0, 32'h8000_0002, 3, 0, 1, 0)));
    vecs.push_back(mk_vec(2, 7,  mk_ent(7, 7, 32'h8000_0002, 3, 7, 1, 0)));
    vecs.push_back(mk_vec(2, 15, mk_ent(15, 15, 32'h8000_0002, 3, 15, 1, 1)));

    repeat (2) @(negedge clk);
    check_reset("rst_held");
    rst = 1'b0;
    @(negedge clk);
    check_reset("idle");

    build_model(1, 2, 1, 2, 3, 4, 5, 6);
    do_run(1, 2, 1, 2, 3, 4, 5, 6, 1'b0, 1'b0, -1);
    compare_model("runA");
    check_table(0);
    chk("runA_cycles", 128'(run_cyc), 128'(48));
    chk("runA_gaps", 128'(run_gap), 128'(0));
    chk("runA_nnz", 128'(act_nnz), 128'(48));

    build_model(0, 3, 5, 32'hFFFF_FFFE, 7, 1, 9, 9);
    do_run(0, 3, 5, 32'hFFFF_FFFE, 7, 1, 9, 9, 1'b0, 1'b0, -1);
    compare_model("runB");
    check_table(1);
    chk("runB_nnz", 128'(act_nnz), 128'(32));

    build_model(0, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 1, 2, 3);
    do_run(0, 0, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 1, 1, 2, 3, 1'b0, 1'b0, -1);
    compare_model("runC");
    check_table(2);
    chk("runC_nnz", 128'(act_nnz), 128'(16));

    build_model(1, 2, 1, 2, 3, 4, 5, 6);
    do_run(1, 2, 1, 2, 3, 4, 5, 6, 1'b1, 1'b0, -1);
    compare_model("runA_stall");
    check_table(0);

    do_run(1, 2, 1, 2, 3, 4, 5, 6, 1'b0, 1'b1, -1);
    compare_model("runA_holdvld");

    do_run(1, 2, 1, 2, 3, 4, 5, 6, 1'b0, 1'b0, 16);
    do_run(1, 2, 1, 2, 3, 4, 5, 6, 1'b0, 1'b0, -1);
    compare_model("runA_after_rst");
    check_table(0);
    chk("runA_after_rst_cycles", 128'(run_cyc), 128'(48));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csc_mat_gen.md
CSC_MAT_GEN -- requirements
Module: csc_mat_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the two's-complement width of each real/imaginary value.
REQ-002 SHALL have parameter SUBCAR_NUM, default 16, meaning the number of subcarriers.
REQ-003 SHALL have parameter OFDM_SYM_NUM, default 16, meaning OFDM symbols per slot; N = SUBCAR_NUM*OFDM_SYM_NUM is the matrix rank; IW = clog2(N).
REQ-004 SHALL have parameter NNZ_COL, default 3, legal 1..3, meaning the nonzeros generated per column before merging.
REQ-005 SHALL have the following ports, one per line: name  direction  width  meaning. Clock and reset come first.
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  reset; asynchronous, active-high.
- par_vld  in  1  parameter set valid.
- par_rdy  out  1  module idle and able to accept a parameter set.
- z0, z1  in  IW  cyclic row offsets of the a0 and a1 diagonals.
- s_r, s_i, a0_r, a0_i, a1_r, a1_i  in  DATA_W each  complex values of the main, a0 and a1 diagonals.
- out_vld  out  1  CSC entry valid.
- out_rdy  in  1  downstream accepts the entry.
- col_idx, row_idx  out  IW  column and row of the entry.
- val_r, val_i  out  DATA_W  entry value.
- col_ptr  out  clog2(3N+1)  CSC column pointer: number of entries emitted before the current column.
- col_last  out  1  last entry of the column.
- mat_last  out  1  last entry of the matrix.
- nnz_total  out  clog2(3N+1)  total entries; valid while mat_last is high.

Function
REQ-006 SHALL implement the states IDLE and RUN only.
REQ-007 In IDLE, par_rdy SHALL be 1; a par_vld&par_rdy handshake SHALL latch all parameter inputs, set column 0, and move the state to RUN.
REQ-008 In RUN, par_rdy SHALL be 0, and par_vld SHALL be ignored with no effect.
REQ-009 For column c, the candidate entries SHALL be:
- k=0: row c, value s.
- k=1: row (c+z0) mod N, value a0.
- k=2: row (c+z1) mod N, value a1.
Only k < NNZ_COL is used. The mod N wrap is exact for non-power-of-two N.
REQ-010 Candidates with equal rows SHALL merge into one entry; the value is the component-wise sum, wrapping modulo 2^DATA_W with no saturation.
REQ-011 The entries of a column SHALL be emitted one per out_vld&out_rdy handshake.
REQ-012 col_last SHALL be high on the final entry of each column; the column index SHALL advance after that handshake.
REQ-013 The first out_vld SHALL assert in the cycle after the parameter handshake.
REQ-014 With out_rdy held at 1, throughput SHALL be one entry per cycle with no gaps across column boundaries.
REQ-015 While out_vld=1 and out_rdy=0, every output SHALL hold stable.
REQ-016 col_ptr SHALL be 0 for column 0; on every column boundary it SHALL increase by the entry count of the completed column.
REQ-017 mat_last SHALL coincide with col_last of column N-1. nnz_total SHALL equal col_ptr plus the final column's count.
REQ-018 After the mat_last handshake, the state SHALL return to IDLE, with par_rdy=1 in the next cycle.

Reset
REQ-019 Asserting rst at any time, including mid-RUN, SHALL immediately force IDLE and the following outputs: par_rdy=1, out_vld=0, col_last=0, mat_last=0, and col_idx=row_idx=val_r=val_i=col_ptr=nnz_total=0.
REQ-020 After rst deasserts, a new parameter handshake SHALL be accepted on the first clock edge.

Configuration
REQ-021 Macro CSC_ROW_SORT_EN SHALL select the order of entries within a column.
- Defined: entries SHALL be emitted in strictly ascending row_idx within each column, as canonical CSC.
- Undefined: entries SHALL be emitted in k order (0,1,2), skipping merged duplicates, and no sort logic SHALL be present.

Verification
(All scenarios use SUBCAR_NUM=4, OFDM_SYM_NUM=4 (N=16), NNZ_COL=3 and out_rdy=1 unless stated otherwise.)
REQ-022 z0=1, z1=2, sort enabled -> 48 entries in 48 consecutive cycles.
- Column 0 emits rows 0,1,2.
- Column 15 emits rows 0,1,15, with col_ptr=45.
- mat_last is high on entry 48, with nnz_total=48.
REQ-023 z0=0, z1=3, s=(5,-2), a0=(7,1) -> each column emits 2 entries. The row-c entry has value (12,-1). nnz_total=32 and col_ptr of column 15 is 30.
REQ-024 z0=1, z1=2, sort disabled -> column 15 emits rows 15,0,1 in that order.
REQ-025 out_rdy pseudo-random with 50% duty -> the entry sequence is identical to REQ-022, and outputs never change during a stall.
REQ-026 par_vld held at 1 during RUN -> only the first set is accepted; par_rdy rises the cycle after mat_last.
REQ-027 rst pulsed during column 5 -> all outputs return to reset values the same cycle. A subsequent run with z0=1, z1=2 reproduces REQ-022 exactly.
